// File: rtl/data_mem_arbiter.sv
// Two-port byte/half/word arbiter and sequencer in front of the Memoria32Data byte-banked RAM.
// Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break (default: port 0 priority).
module data_mem_arbiter #(
    parameter int unsigned MEM_ABITS = 12
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [1:0]  p0_size,
    input  logic        p0_unsigned,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_acc,
    output logic        p0_rsp_valid,
    output logic        p0_rsp_err,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [1:0]  p1_size,
    input  logic        p1_unsigned,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_acc,
    output logic        p1_rsp_valid,
    output logic        p1_rsp_err,
    output logic [31:0] p1_rdata,
    output logic [31:0] mem_raddress,
    output logic [31:0] mem_waddress,
    output logic [31:0] mem_datain,
    output logic [3:0]  mem_wr,
    input  logic [31:0] mem_dataout
);

    localparam int unsigned SUM_W = MEM_ABITS + 1;

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        port_q, port_d;
    logic        err_q, err_d;
    logic        last_q, last_d;
    logic [31:0] p0_rdata_q, p0_rdata_d;
    logic [31:0] p1_rdata_q, p1_rdata_d;

    logic        gnt_port;
    logic        sel_we;
    logic [1:0]  sel_size;
    logic        sel_uns;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [1:0]  sel_last;
    logic [SUM_W-1:0] end_sum;
    logic        sel_err;
    logic [3:0]  wr_mask;
    logic [31:0] ext_data;

    // Tie-break between simultaneous requests; a lone requester always wins
`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign gnt_port = (p0_req && p1_req) ? ~last_q : p1_req;
`else
    assign gnt_port = ~p0_req;
`endif

    assign sel_we    = gnt_port ? p1_we       : p0_we;
    assign sel_size  = gnt_port ? p1_size     : p0_size;
    assign sel_uns   = gnt_port ? p1_unsigned : p0_unsigned;
    assign sel_addr  = gnt_port ? p1_addr     : p0_addr;
    assign sel_wdata = gnt_port ? p1_wdata    : p0_wdata;

    // Range check: high address bits set, last byte past the RAM, or reserved size
    always_comb begin
        sel_last = 2'd0;
        unique case (sel_size)
            2'b01:   sel_last = 2'd1;
            2'b10:   sel_last = 2'd3;
            default: sel_last = 2'd0;
        endcase
        end_sum = {1'b0, sel_addr[MEM_ABITS-1:0]} + SUM_W'(sel_last);
        sel_err = (sel_size == 2'b11) || (|sel_addr[31:MEM_ABITS]) || end_sum[MEM_ABITS];
    end

    // Byte enables and load extension from the latched size
    always_comb begin
        wr_mask  = 4'b0000;
        ext_data = mem_dataout;
        unique case (size_q)
            2'b00: begin
                wr_mask  = 4'b0001;
                ext_data = {{24{~uns_q & mem_dataout[7]}}, mem_dataout[7:0]};
            end
            2'b01: begin
                wr_mask  = 4'b0011;
                ext_data = {{16{~uns_q & mem_dataout[15]}}, mem_dataout[15:0]};
            end
            2'b10: wr_mask = 4'b1111;
            default: wr_mask = 4'b0000;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        port_d       = port_q;
        err_d        = err_q;
        last_d       = last_q;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        p0_acc       = 1'b0;
        p1_acc       = 1'b0;
        p0_rsp_valid = 1'b0;
        p1_rsp_valid = 1'b0;
        p0_rsp_err   = 1'b0;
        p1_rsp_err   = 1'b0;
        mem_raddress = 32'h0;
        mem_datain   = 32'h0;
        mem_wr       = 4'b0000;
        unique case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    p0_acc  = ~gnt_port;
                    p1_acc  = gnt_port;
                    we_d    = sel_we;
                    size_d  = sel_size;
                    uns_d   = sel_uns;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    port_d  = gnt_port;
                    err_d   = sel_err;
                    last_d  = gnt_port;
                    if (sel_err || sel_we) begin
                        if (gnt_port) p1_rdata_d = 32'h0;
                        else          p0_rdata_d = 32'h0;
                    end
                    state_d = sel_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_raddress = addr_q;
                mem_datain   = wdata_q;
                mem_wr       = we_q ? wr_mask : 4'b0000;
                state_d      = we_q ? RESP : CAPTURE;
            end
            CAPTURE: begin
                mem_raddress = addr_q;
                if (port_q) p1_rdata_d = ext_data;
                else        p0_rdata_d = ext_data;
                state_d = RESP;
            end
            RESP: begin
                p0_rsp_valid = ~port_q;
                p1_rsp_valid = port_q;
                p0_rsp_err   = ~port_q & err_q;
                p1_rsp_err   = port_q & err_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_waddress = mem_raddress;
    assign p0_rdata     = p0_rdata_q;
    assign p1_rdata     = p1_rdata_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            port_q     <= 1'b0;
            err_q      <= 1'b0;
            last_q     <= 1'b1;
            p0_rdata_q <= 32'h0;
            p1_rdata_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            port_q     <= port_d;
            err_q      <= err_d;
            last_q     <= last_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

endmodule
